// File: rtl/uart_bram_dump_pkg.sv
// Shared definitions for the BRAM-to-UART dump engine.
//   DEF_*   : default parameter values for the top and the address generator
//   state_e : dump FSM state encoding
package uart_bram_dump_pkg;

   localparam int unsigned DEF_ADDR_W      = 12;
   localparam int unsigned DEF_DATA_W      = 8;
   localparam int unsigned DEF_RD_LAT      = 1;
   localparam int unsigned DEF_ACK_TIMEOUT = 4;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRdWait,
      StLoad,
      StTxWait,
      StSend,
      StAck,
      StFin
   } state_e;

endpackage

// File: rtl/uart_bram_dump_addr_gen.sv
// Address/count bookkeeping for one dump run.
//   clk, rst        : clock, async active-low reset
//   load            : accepted start; latches base/length and clears the count
//   advance         : current byte handed off; bump pointer and count
//   base_addr       : first address of the run
//   length          : bytes in the run (0..2^ADDR_W)
//   ptr, nxt_ptr    : current read pointer and its wrapped successor
//   sent_cnt        : bytes handed off so far
//   last            : the byte in flight is the final one of the run
module uart_bram_dump_addr_gen
   import uart_bram_dump_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] ptr,
   output logic [ADDR_W-1:0] nxt_ptr,
   output logic [ADDR_W:0]   sent_cnt,
   output logic              last
);

   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE = 1;

   logic [ADDR_W:0] len_q;

   // Natural overflow of the ADDR_W-bit add gives the modulo-2^ADDR_W wrap.
   assign nxt_ptr = ptr + PTR_ONE;
   assign last    = (sent_cnt + CNT_ONE) == len_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr      <= '0;
         len_q    <= '0;
         sent_cnt <= '0;
      end else if (load) begin
         ptr      <= base_addr;
         len_q    <= length;
         sent_cnt <= '0;
      end else if (advance) begin
         ptr      <= nxt_ptr;
         sent_cnt <= sent_cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/uart_bram_dump.sv
// Streams a contiguous (possibly wrapping) BRAM range out through UART_tx,
// one byte in flight at a time.
//   clk, rst               : clock, async active-low reset
//   start, abort           : run request (IDLE only) and synchronous abort
//   base_addr, length      : run range, latched on accepted start
//   bram_en/addr/dout      : BRAM read port
//   tx_busy, tx_start      : UART_tx handshake
//   byte_to_send           : byte for UART_tx, held until the next load
//   busy, done, err        : run active, end-of-run pulse, sticky ack timeout
//   cur_addr, sent_cnt     : last loaded address, bytes handed off this run
module uart_bram_dump
   import uart_bram_dump_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned RD_LAT      = DEF_RD_LAT,
   parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_dout,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [DATA_W-1:0] byte_to_send,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] cur_addr,
   output logic [ADDR_W:0]   sent_cnt
);

   localparam int unsigned      TMO_W     = $clog2(ACK_TIMEOUT + 1);
   localparam logic [1:0]       WAIT_LAST = 2'(RD_LAT - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);

   state_e            state;
   logic [1:0]        wait_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              load;
   logic              advance;
   logic              ack_expired;
   logic              last;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] nxt_ptr;

   assign load        = (state == StIdle) && start && !abort;
   assign ack_expired = (tmo_cnt == TMO_LAST);
   // A timed-out byte is still counted so the run always terminates.
   assign advance     = (state == StAck) && !abort && (tx_busy || ack_expired);

   uart_bram_dump_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .advance   (advance),
      .base_addr (base_addr),
      .length    (length),
      .ptr       (ptr),
      .nxt_ptr   (nxt_ptr),
      .sent_cnt  (sent_cnt),
      .last      (last)
   );

   // bram_en/tx_start are set on entry to RD/SEND so they are visible while in
   // those states; done is set on leaving FIN, together with busy dropping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= StIdle;
         wait_cnt     <= '0;
         tmo_cnt      <= '0;
         bram_en      <= 1'b0;
         bram_addr    <= '0;
         tx_start     <= 1'b0;
         byte_to_send <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         cur_addr     <= '0;
      end else begin
         bram_en  <= 1'b0;
         tx_start <= 1'b0;
         done     <= 1'b0;
         if (abort) begin
            if (state != StIdle) begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         end else begin
            unique case (state)
               StIdle: begin
                  if (start) begin
                     busy <= 1'b1;
                     err  <= 1'b0;
                     if (length == '0) begin
                        state <= StFin;
                     end else begin
                        state     <= StRd;
                        bram_en   <= 1'b1;
                        bram_addr <= base_addr;
                     end
                  end
               end
               StRd: begin
                  state    <= StRdWait;
                  wait_cnt <= '0;
               end
               StRdWait: begin
                  if (wait_cnt == WAIT_LAST) state <= StLoad;
                  else                       wait_cnt <= wait_cnt + 2'd1;
               end
               StLoad: begin
                  byte_to_send <= bram_dout;
                  cur_addr     <= ptr;
                  state        <= StTxWait;
               end
               StTxWait: begin
                  if (!tx_busy) begin
                     state    <= StSend;
                     tx_start <= 1'b1;
                  end
               end
               StSend: begin
                  state   <= StAck;
                  tmo_cnt <= '0;
               end
               StAck: begin
                  if (tx_busy || ack_expired) begin
                     if (!tx_busy) err <= 1'b1;
                     if (last) begin
                        state <= StFin;
                     end else begin
                        state     <= StRd;
                        bram_en   <= 1'b1;
                        bram_addr <= nxt_ptr;
                     end
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
               end
               StFin: begin
                  state <= StIdle;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_bram_dump.sv
// Bench for uart_bram_dump: instance 0 uses RD_LAT=1, instance 1 RD_LAT=2.
module tb_uart_bram_dump;

   logic        clk = 1'b0;
   logic        rst;
   logic        abort;
   logic        force_busy;
   logic [11:0] base_addr;
   logic [12:0] length;
   int          busy_len;

   logic        start_v    [2];
   logic        bram_en_v  [2];
   logic [11:0] bram_addr_v[2];
   logic [7:0]  dout_v     [2];
   logic        tx_busy_v  [2];
   logic        tx_start_v [2];
   logic [7:0]  byte_v     [2];
   logic        busy_v     [2];
   logic        done_v     [2];
   logic        err_v      [2];
   logic [11:0] cur_addr_v [2];
   logic [12:0] sent_v     [2];

   logic [7:0]  mem [4096];
   logic [7:0]  stage1;
   logic        v1;
   int          tcnt [2];
   int          txq [$];
   int          aq [$];
   int          done_cnt [2];
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   uart_bram_dump #(.RD_LAT(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort),
      .base_addr(base_addr), .length(length), .bram_en(bram_en_v[0]),
      .bram_addr(bram_addr_v[0]), .bram_dout(dout_v[0]), .tx_busy(tx_busy_v[0]),
      .tx_start(tx_start_v[0]), .byte_to_send(byte_v[0]), .busy(busy_v[0]),
      .done(done_v[0]), .err(err_v[0]), .cur_addr(cur_addr_v[0]), .sent_cnt(sent_v[0])
   );

   uart_bram_dump #(.RD_LAT(2)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort),
      .base_addr(base_addr), .length(length), .bram_en(bram_en_v[1]),
      .bram_addr(bram_addr_v[1]), .bram_dout(dout_v[1]), .tx_busy(tx_busy_v[1]),
      .tx_start(tx_start_v[1]), .byte_to_send(byte_v[1]), .busy(busy_v[1]),
      .done(done_v[1]), .err(err_v[1]), .cur_addr(cur_addr_v[1]), .sent_cnt(sent_v[1])
   );

   // BRAM models: 1-cycle and 2-cycle read latency, output held between reads.
   always @(posedge clk) begin
      if (bram_en_v[0]) dout_v[0] <= mem[bram_addr_v[0]];
      v1 <= bram_en_v[1];
      if (bram_en_v[1]) stage1 <= mem[bram_addr_v[1]];
      if (v1) dout_v[1] <= stage1;
   end

   // UART_tx model: busy for busy_len cycles after tx_start (0 = never acks).
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (tx_start_v[g])    tcnt[g] <= busy_len;
         else if (tcnt[g] > 0) tcnt[g] <= tcnt[g] - 1;
      end
   end

   always_comb begin
      for (int g = 0; g < 2; g++) tx_busy_v[g] = force_busy | (tcnt[g] != 0);
   end

   function automatic void chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endfunction

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (tx_start_v[g]) begin
            txq.push_back(g * 256 + int'(byte_v[g]));
            chk("tx_start_while_busy", int'(tx_busy_v[g]), 0);
         end
         if (bram_en_v[g]) aq.push_back(g * 65536 + int'(bram_addr_v[g]));
         if (done_v[g]) done_cnt[g]++;
      end
   end

   task automatic chk_zero(input int g, input string tag);
      chk({tag, "_busy"}, int'(busy_v[g]), 0);
      chk({tag, "_done"}, int'(done_v[g]), 0);
      chk({tag, "_err"}, int'(err_v[g]), 0);
      chk({tag, "_tx_start"}, int'(tx_start_v[g]), 0);
      chk({tag, "_bram_en"}, int'(bram_en_v[g]), 0);
      chk({tag, "_bram_addr"}, int'(bram_addr_v[g]), 0);
      chk({tag, "_byte"}, int'(byte_v[g]), 0);
      chk({tag, "_cur_addr"}, int'(cur_addr_v[g]), 0);
      chk({tag, "_sent_cnt"}, int'(sent_v[g]), 0);
   endtask

   task automatic wait_tx_idle(input int g);
      int k = 0;
      while (tx_busy_v[g] && k < 200) begin
         @(negedge clk);
         k++;
      end
   endtask

   // One dump run checked against the reference: bytes are mem[(base+i) mod 4096].
   task automatic do_run(input int g, input int base, input int len, input int blen,
                         input bit exp_err, input int exp_last, input int bp,
                         input int restart, input string nm);
      int n = 0;
      int lat = -1;
      int cyc_done = -1;
      int done0;
      int budget;
      bit got_done = 1'b0;
      busy_len = blen;
      wait_tx_idle(g);
      txq.delete();
      aq.delete();
      done0 = done_cnt[g];
      budget = len * (blen + 16) + bp + 100;
      base_addr = 12'(base);
      length = 13'(len);
      start_v[g] = 1'b1;
      force_busy = (bp > 0);
      while (!got_done && n < budget) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            start_v[g] = 1'b0;
            chk({nm, "_err_cleared"}, int'(err_v[g]), 0);
            chk({nm, "_busy_on_start"}, int'(busy_v[g]), 1);
         end
         if (bp > 0 && n == bp) force_busy = 1'b0;
         if (n == restart) begin
            start_v[g] = 1'b1;
            base_addr = 12'(base + 'h555);
            length = 13'(7);
         end else if (restart > 0 && n == restart + 1) begin
            start_v[g] = 1'b0;
         end
         if (tx_start_v[g] && lat < 0) lat = n;
         if (done_v[g]) begin
            got_done = 1'b1;
            cyc_done = n;
         end
      end
      chk({nm, "_done_seen"}, int'(got_done), 1);
      if (len == 0)    chk({nm, "_done_latency"}, cyc_done, 2);
      else if (bp > 0) chk({nm, "_tx_after_backpressure"}, lat, bp + 1);
      else             chk({nm, "_first_tx_latency"}, lat, 5 + g);
      repeat (3) @(negedge clk);
      chk({nm, "_done_pulses"}, done_cnt[g] - done0, 1);
      chk({nm, "_busy_after"}, int'(busy_v[g]), 0);
      chk({nm, "_sent_cnt"}, int'(sent_v[g]), len);
      chk({nm, "_err"}, int'(err_v[g]), int'(exp_err));
      if (exp_last >= 0) chk({nm, "_cur_addr"}, int'(cur_addr_v[g]), exp_last);
      chk({nm, "_tx_count"}, txq.size(), len);
      chk({nm, "_rd_count"}, aq.size(), len);
      for (int i = 0; i < len && i < txq.size(); i++)
         chk({nm, "_byte"}, txq[i], g * 256 + int'(mem[(base + i) % 4096]));
      for (int i = 0; i < len && i < aq.size(); i++)
         chk({nm, "_bram_addr"}, aq[i], g * 65536 + ((base + i) % 4096));
   endtask

   typedef struct {
      int inst;
      int base;
      int len;
      int blen;
      bit exp_err;
      int exp_last;
      int bp;
      int restart;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int k;
      int g;
      int b;
      int l;
      int bl;
      rst = 1'b0;
      abort = 1'b0;
      force_busy = 1'b0;
      busy_len = 10;
      base_addr = '0;
      length = '0;
      start_v[0] = 1'b0;
      start_v[1] = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      mem['h010] = 8'h41;
      mem['h011] = 8'h42;
      mem['h012] = 8'h43;
      mem['h013] = 8'h44;

      vecs[0] = '{0, 'h010, 4, 10, 1'b0, 'h013, 0, 0};     // basic
      vecs[1] = '{1, 'h010, 4, 10, 1'b0, 'h013, 0, 0};     // RD_LAT=2
      vecs[2] = '{0, 'hFFE, 4, 10, 1'b0, 'h001, 0, 0};     // wrap
      vecs[3] = '{0, 'h000, 0, 10, 1'b0, -1, 0, 0};        // zero length
      vecs[4] = '{0, 'h100, 3, 0, 1'b1, 'h102, 0, 0};      // ack timeout
      vecs[5] = '{0, 'h200, 5, 10, 1'b0, 'h204, 50, 60};   // back-pressure + ignored start
      vecs[6] = '{1, 'h7FF, 1, 3, 1'b0, 'h7FF, 0, 0};
      vecs[7] = '{0, 'h123, 4096, 1, 1'b0, 'h122, 0, 0};   // whole memory

      #1;
      chk_zero(0, "reset0");
      chk_zero(1, "reset1");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         do_run(vecs[i].inst, vecs[i].base, vecs[i].len, vecs[i].blen, vecs[i].exp_err,
                vecs[i].exp_last, vecs[i].bp, vecs[i].restart, $sformatf("vec%0d", i));
         if (i == 0 && txq.size() > 0) chk("basic_first_byte", txq[0], 'h41);
      end

      // Reset asserted while tx_start is up.
      busy_len = 10;
      wait_tx_idle(0);
      base_addr = 12'h300;
      length = 13'd6;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      k = 0;
      while (!tx_start_v[0] && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("rst_reached_send", int'(tx_start_v[0]), 1);
      #2 rst = 1'b0;
      #1 chk_zero(0, "rst_mid");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      txq.delete();
      repeat (20) @(negedge clk);
      chk("rst_no_tx_after", txq.size(), 0);
      do_run(0, 'h010, 4, 10, 1'b0, 'h013, 0, 0, "after_rst");

      // Abort after the second byte of an 8-byte run.
      busy_len = 4;
      wait_tx_idle(0);
      txq.delete();
      k = done_cnt[0];
      base_addr = 12'h040;
      length = 13'd8;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      l = 0;
      while (sent_v[0] != 13'd2 && l < 300) begin
         @(negedge clk);
         l++;
      end
      chk("abort_reached_2", int'(sent_v[0]), 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy_low", int'(busy_v[0]), 0);
      repeat (40) @(negedge clk);
      chk("abort_tx_count", txq.size(), 2);
      chk("abort_no_done", done_cnt[0] - k, 0);
      chk("abort_sent_cnt", int'(sent_v[0]), 2);
      start_v[0] = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      abort = 1'b0;
      chk("abort_beats_start_busy", int'(busy_v[0]), 0);
      chk("abort_beats_start_cnt", int'(sent_v[0]), 2);

      // Randomized runs against the reference.
      for (int r = 0; r < 20; r++) begin
         g = int'($urandom_range(1, 0));
         b = int'($urandom_range(4095, 0));
         l = int'($urandom_range(24, 1));
         bl = int'($urandom_range(12, 0));
         do_run(g, b, l, bl, bl == 0, (b + l - 1) % 4096, 0, 0, $sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
